// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the junction light sequencer and the lamp drivers.
// Optional FAULT_COUNT_EN adds a saturating fault_count output.
`timescale 1ns/1ps
module traffic_conflict_monitor #(
    parameter int unsigned CONFIRM      = 2,
    parameter int unsigned MAX_HOLD     = 15,
    parameter int unsigned FLASH_TICKS  = 1,
    parameter int unsigned ALLRED_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] light_L_R,
    input  logic [2:0] light_D_R,
    input  logic [2:0] light_L_D,
    input  logic [2:0] light_R_L_D,
    input  logic       fault_clr,
    output logic [2:0] lamp_L_R,
    output logic [2:0] lamp_D_R,
    output logic [2:0] lamp_L_D,
    output logic [2:0] lamp_R_L_D,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] mon_state
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam logic [1:0] ST_MONITOR = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_FAULT   = 2'b10;
    localparam logic [1:0] ST_RECOVER = 2'b11;

    localparam logic [1:0] CODE_ENC      = 2'b01;
    localparam logic [1:0] CODE_CONFLICT = 2'b10;
    localparam logic [1:0] CODE_STUCK    = 2'b11;

    localparam logic [11:0] ALL_RED = 12'h924;
    localparam logic [11:0] ALL_OFF = 12'h000;

    localparam logic [3:0] CONFIRM_V = 4'(CONFIRM);
    localparam logic [7:0] HOLD_V    = 8'(MAX_HOLD);
    localparam logic [7:0] FLASH_V   = 8'(FLASH_TICKS);
    localparam logic [7:0] ALLRED_V  = 8'(ALLRED_TICKS);

    function automatic logic is_legal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
    endfunction

    function automatic logic is_go(input logic [2:0] c);
        return (c == 3'b010) || (c == 3'b001);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [11:0] lamps_q, lamps_d;
    logic [11:0] prev_q;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;
    logic [3:0]  vcnt_q, vcnt_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  flash_q, flash_d;
    logic [7:0]  allred_q, allred_d;
    logic        phase_q, phase_d;
    logic        enter_fault;

    logic [11:0] bundle;
    logic        enc_viol, conf_viol, viol, change, stuck, confirm;
    logic [1:0]  viol_code;
    logic [3:0]  vcnt_inc;
    logic [7:0]  hold_inc, flash_inc, allred_inc;

    assign bundle = {light_L_R, light_D_R, light_L_D, light_R_L_D};

    // Input classification: encoding errors outrank go-signal conflicts
    assign enc_viol  = !is_legal(light_L_R) || !is_legal(light_D_R) ||
                       !is_legal(light_L_D) || !is_legal(light_R_L_D);
    assign conf_viol = (is_go(light_D_R) &&
                        (is_go(light_L_R) || is_go(light_L_D) || is_go(light_R_L_D))) ||
                       (is_go(light_R_L_D) && is_go(light_L_D));
    assign viol      = enc_viol || conf_viol;
    assign viol_code = enc_viol ? CODE_ENC : CODE_CONFLICT;

    assign vcnt_inc   = (vcnt_q == 4'hF)   ? vcnt_q   : vcnt_q + 4'd1;
    assign hold_inc   = (hold_q == 8'hFF)  ? hold_q   : hold_q + 8'd1;
    assign flash_inc  = (flash_q == 8'hFF) ? flash_q  : flash_q + 8'd1;
    assign allred_inc = (allred_q == 8'hFF) ? allred_q : allred_q + 8'd1;

    assign change  = (bundle != prev_q);
    assign stuck   = tick && !change && (hold_inc >= HOLD_V);
    // vcnt is 0 in MONITOR, so this also covers the CONFIRM=1 immediate fault
    assign confirm = viol && (vcnt_inc >= CONFIRM_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RECOVER;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        lamps_d     = lamps_q;
        fault_d     = fault_q;
        code_d      = code_q;
        vcnt_d      = vcnt_q;
        hold_d      = hold_q;
        flash_d     = flash_q;
        allred_d    = allred_q;
        phase_d     = phase_q;
        enter_fault = 1'b0;
        case (state_q)
            ST_MONITOR, ST_PENDING: begin
                hold_d = change ? 8'd0 : (tick ? hold_inc : hold_q);
                if (confirm) begin
                    enter_fault = 1'b1;
                    code_d      = viol_code;
                end else if (stuck) begin
                    enter_fault = 1'b1;
                    code_d      = CODE_STUCK;
                end else if (viol) begin
                    state_d = ST_PENDING;
                    vcnt_d  = vcnt_inc;
                end else begin
                    state_d = ST_MONITOR;
                    vcnt_d  = 4'd0;
                    if (state_q == ST_MONITOR) lamps_d = bundle;
                end
                if (enter_fault) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    lamps_d = ALL_RED;
                    phase_d = 1'b1;
                    flash_d = 8'd0;
                    vcnt_d  = 4'd0;
                    hold_d  = 8'd0;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !viol) begin
                    state_d  = ST_RECOVER;
                    fault_d  = 1'b0;
                    lamps_d  = ALL_RED;
                    allred_d = 8'd0;
                end else if (tick) begin
                    if (flash_inc >= FLASH_V) begin
                        flash_d = 8'd0;
                        phase_d = !phase_q;
                        lamps_d = phase_q ? ALL_OFF : ALL_RED;
                    end else begin
                        flash_d = flash_inc;
                    end
                end
            end
            ST_RECOVER: begin
                lamps_d = ALL_RED;
                if (tick) begin
                    if (allred_inc >= ALLRED_V) begin
                        state_d  = ST_MONITOR;
                        hold_d   = 8'd0;
                        vcnt_d   = 4'd0;
                        allred_d = 8'd0;
                    end else begin
                        allred_d = allred_inc;
                    end
                end
            end
            default: state_d = ST_RECOVER;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps_q  <= ALL_RED;
            prev_q   <= 12'd0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
            vcnt_q   <= 4'd0;
            hold_q   <= 8'd0;
            flash_q  <= 8'd0;
            allred_q <= 8'd0;
            phase_q  <= 1'b1;
        end else begin
            lamps_q  <= lamps_d;
            prev_q   <= bundle;
            fault_q  <= fault_d;
            code_q   <= code_d;
            vcnt_q   <= vcnt_d;
            hold_q   <= hold_d;
            flash_q  <= flash_d;
            allred_q <= allred_d;
            phase_q  <= phase_d;
        end
    end

`ifdef FAULT_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   fault_count <= 8'd0;
        else if (enter_fault && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
    end
`endif

    assign {lamp_L_R, lamp_D_R, lamp_L_D, lamp_R_L_D} = lamps_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign mon_state  = state_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed scoreboard bench for traffic_conflict_monitor (default parameters).
`timescale 1ns/1ps
module tb_traffic_conflict_monitor;

    typedef struct packed {
        logic [11:0] lamps;
        logic        fault;
        logic [1:0]  code;
        logic [1:0]  st;
    } exp_t;

    localparam logic [11:0] A  = 12'h321;  // L_R go, R_L_D go
    localparam logic [11:0] B  = 12'h30C;  // L_R go, L_D go
    localparam logic [11:0] C  = 12'h522;  // L_R yellow, R_L_D yellow
    localparam logic [11:0] X  = 12'h264;  // D_R go with L_R go: conflict
    localparam logic [11:0] E  = 12'h25C;  // L_D=011 plus conflict: encoding
    localparam logic [11:0] AR = 12'h924;
    localparam logic [11:0] DK = 12'h000;

    logic       clk = 1'b0;
    logic       rst, tick, fault_clr;
    logic [2:0] light_L_R, light_D_R, light_L_D, light_R_L_D;
    logic [2:0] lamp_L_R, lamp_D_R, lamp_L_D, lamp_R_L_D;
    logic       fault;
    logic [1:0] fault_code, mon_state;
`ifdef FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   stepn  = 0;
    exp_t sb[$];

    traffic_conflict_monitor dut (
        .clk(clk), .rst(rst), .tick(tick),
        .light_L_R(light_L_R), .light_D_R(light_D_R),
        .light_L_D(light_L_D), .light_R_L_D(light_R_L_D),
        .fault_clr(fault_clr),
        .lamp_L_R(lamp_L_R), .lamp_D_R(lamp_D_R),
        .lamp_L_D(lamp_L_D), .lamp_R_L_D(lamp_R_L_D),
        .fault(fault), .fault_code(fault_code), .mon_state(mon_state)
`ifdef FAULT_COUNT_EN
        , .fault_count(fault_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, stepn, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard step %0d: observed empty queue expected entry", stepn);
        end else begin
            e = sb.pop_front();
            chk("lamps", {lamp_L_R, lamp_D_R, lamp_L_D, lamp_R_L_D}, e.lamps);
            chk("fault", 12'(fault), 12'(e.fault));
            chk("fault_code", 12'(fault_code), 12'(e.code));
            chk("mon_state", 12'(mon_state), 12'(e.st));
        end
    endtask

    task automatic drive(input logic [11:0] b, input logic t, input logic c);
        {light_L_R, light_D_R, light_L_D, light_R_L_D} = b;
        tick      = t;
        fault_clr = c;
    endtask

    // One clk cycle: drive, push expectation, clock, pop and compare
    task automatic step(input logic [11:0] b, input logic t, input logic c,
                        input logic [11:0] el, input logic ef,
                        input logic [1:0] ec, input logic [1:0] es);
        stepn++;
        drive(b, t, c);
        sb.push_back('{lamps: el, fault: ef, code: ec, st: es});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        drive(A, 1'b0, 1'b0);
        #3;
        sb.push_back('{lamps: AR, fault: 1'b0, code: 2'b00, st: 2'b11});
        check_out();
        rst = 1'b0;

        // RECOVER: three ticks of all-red, one every 4 clk
        for (int i = 0; i < 2; i++) begin
            repeat (3) step(A, 1'b0, 1'b0, AR, 1'b0, 2'd0, 2'd3);
            step(A, 1'b1, 1'b0, AR, 1'b0, 2'd0, 2'd3);
        end
        repeat (3) step(A, 1'b0, 1'b0, AR, 1'b0, 2'd0, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd0, 2'd0);

        // Pass-through with 1-clk latency
        step(A, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd0);
        step(B, 1'b0, 1'b0, B, 1'b0, 2'd0, 2'd0);
        step(C, 1'b0, 1'b0, C, 1'b0, 2'd0, 2'd0);
        step(A, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd0);

        // Single-cycle conflict: PENDING, frozen lamps, back to MONITOR
        step(X, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd1);
        step(B, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd0);
        step(B, 1'b0, 1'b0, B, 1'b0, 2'd0, 2'd0);

        // Two-cycle conflict: fault code 10
        step(X, 1'b0, 1'b0, B, 1'b0, 2'd0, 2'd1);
        step(X, 1'b0, 1'b0, AR, 1'b1, 2'd2, 2'd2);

        // Flashing, and clear refused while conflict persists
        step(X, 1'b1, 1'b0, DK, 1'b1, 2'd2, 2'd2);
        step(X, 1'b0, 1'b0, DK, 1'b1, 2'd2, 2'd2);
        step(X, 1'b1, 1'b0, AR, 1'b1, 2'd2, 2'd2);
        step(X, 1'b0, 1'b1, AR, 1'b1, 2'd2, 2'd2);
        step(X, 1'b1, 1'b1, DK, 1'b1, 2'd2, 2'd2);

        // Legal inputs plus clear: RECOVER for 3 ticks, stray clear ignored
        step(A, 1'b0, 1'b1, AR, 1'b0, 2'd2, 2'd3);
        step(A, 1'b1, 1'b1, AR, 1'b0, 2'd2, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd2, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd2, 2'd0);
        step(A, 1'b0, 1'b0, A, 1'b0, 2'd2, 2'd0);

        // Encoding beats conflict; lamps alternate on each tick
        step(E, 1'b0, 1'b0, A, 1'b0, 2'd2, 2'd1);
        step(E, 1'b0, 1'b0, AR, 1'b1, 2'd1, 2'd2);
        step(E, 1'b1, 1'b0, DK, 1'b1, 2'd1, 2'd2);
        step(E, 1'b1, 1'b0, AR, 1'b1, 2'd1, 2'd2);
        step(E, 1'b1, 1'b0, DK, 1'b1, 2'd1, 2'd2);
        step(E, 1'b0, 1'b1, DK, 1'b1, 2'd1, 2'd2);
        step(A, 1'b0, 1'b1, AR, 1'b0, 2'd1, 2'd3);
        repeat (2) step(A, 1'b1, 1'b0, AR, 1'b0, 2'd1, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd1, 2'd0);

        // Stuck watchdog: fault on the 15th unchanged tick
        repeat (14) step(A, 1'b1, 1'b0, A, 1'b0, 2'd1, 2'd0);
        step(A, 1'b1, 1'b0, AR, 1'b1, 2'd3, 2'd2);
        step(A, 1'b1, 1'b0, DK, 1'b1, 2'd3, 2'd2);
        step(A, 1'b0, 1'b0, DK, 1'b1, 2'd3, 2'd2);

        // Asynchronous reset mid-flash
        #2;
        rst = 1'b1;
        #1;
        stepn++;
        sb.push_back('{lamps: AR, fault: 1'b0, code: 2'b00, st: 2'b11});
        check_out();
        rst = 1'b0;

        // Two faults after reset
        repeat (2) step(A, 1'b1, 1'b0, AR, 1'b0, 2'd0, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd0, 2'd0);
        step(A, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd0);
        step(X, 1'b0, 1'b0, A, 1'b0, 2'd0, 2'd1);
        step(X, 1'b0, 1'b0, AR, 1'b1, 2'd2, 2'd2);
        step(A, 1'b0, 1'b1, AR, 1'b0, 2'd2, 2'd3);
        repeat (2) step(A, 1'b1, 1'b0, AR, 1'b0, 2'd2, 2'd3);
        step(A, 1'b1, 1'b0, AR, 1'b0, 2'd2, 2'd0);
        step(X, 1'b0, 1'b0, AR, 1'b0, 2'd2, 2'd1);
        step(X, 1'b0, 1'b0, AR, 1'b1, 2'd2, 2'd2);
`ifdef FAULT_COUNT_EN
        chk("fault_count", 12'(fault_count), 12'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of the junction light-sequence FSM.
- Consumes the four 3-bit light codes (L_R, D_R, L_D, R_L_D) and drives the physical lamp outputs.
- Registers the codes through to the lamps while they are legal.
- On an illegal pattern (bad encoding, conflicting go-signals, or a stuck sequencer) it latches a fault and forces all approaches to flashing red until an operator clear and an all-red recovery interval.

Parameters:
CONFIRM, 2, consecutive clk cycles an encoding/conflict violation must persist before faulting (1..15)
MAX_HOLD, 15, ticks the input bundle may stay unchanged before a stuck fault (2..255)
FLASH_TICKS, 1, ticks per flash half-period in fault (1..255)
ALLRED_TICKS, 3, ticks of solid all-red in RECOVER before pass-through (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-clk-wide timing enable, same rate as sequencer count
light_L_R  in  3  sequencer code: 100 red, 010 yellow, 001 green
light_D_R  in  3  as above
light_L_D  in  3  as above
light_R_L_D  in  3  as above
fault_clr  in  1  operator clear, level-sampled
lamp_L_R  out  3  registered lamp drive, same encoding
lamp_D_R  out  3  registered lamp drive
lamp_L_D  out  3  registered lamp drive
lamp_R_L_D  out  3  registered lamp drive
fault  out  1  high while in FAULT
fault_code  out  2  00 none, 01 encoding, 10 conflict, 11 stuck
mon_state  out  2  00 MONITOR, 01 PENDING, 10 FAULT, 11 RECOVER

Behaviour:
- Reset (clk-independent): state RECOVER, all lamps 3'b100, fault 0, fault_code 00, all counters 0, flash phase 1.
- go(x) means code is 010 or 001.
- Encoding violation: any input code not in {100, 010, 001}.
- Conflict violation: go(D_R) together with go of any other approach, or go(R_L_D) together with go(L_D).
- Legal by design: L_R with R_L_D, and L_R with L_D.
- Violation priority when several apply: encoding > conflict.
- MONITOR:
  - lamps <= inputs each clk (1-cycle latency).
  - Violation with CONFIRM=1 -> FAULT immediately; otherwise -> PENDING with vcnt=1 and lamps frozen.
- PENDING:
  - lamps stay frozen at the last legal value.
  - Violation still present: vcnt+1.
  - When vcnt+1 == CONFIRM -> FAULT, code taken from the violation present in that cycle.
  - Violation absent -> MONITOR, vcnt=0, pass-through resumes the next cycle.
- Stuck watchdog (MONITOR/PENDING only):
  - The previous input bundle is sampled every clk.
  - Any change clears hold_cnt (8-bit).
  - A tick with an unchanged bundle increments hold_cnt.
  - hold_cnt reaching MAX_HOLD -> FAULT, code 11, with no confirm.
  - A same-cycle encoding/conflict confirm takes precedence over stuck.
- Entering FAULT:
  - fault=1; fault_code latched; lamps all 100; phase=1; flash counter 0.
- FAULT:
  - On each tick the flash counter increments.
  - At FLASH_TICKS the counter resets and phase toggles; lamps = phase ? 100 : 000 on all four.
- FAULT exit:
  - fault_clr=1 in a cycle where the inputs have no encoding/conflict violation -> RECOVER.
  - On that transition: fault=0, lamps 100, allred counter 0.
  - fault_clr outside FAULT is ignored.
- RECOVER:
  - Lamps solid 100.
  - Counts ticks; at ALLRED_TICKS -> MONITOR with hold_cnt=0, vcnt=0.
  - A violation seen in RECOVER is not checked; it is evaluated once in MONITOR.
- fault_code holds its value until the next fault latch or reset.
- All counters saturate at their terminal value and never wrap.
- rst asserted mid-operation returns to the reset state immediately.

Optional Feature:
- Macro: FAULT_COUNT_EN.
- Defined:
  - Adds output fault_count (8 bits), reset 0.
  - Increments on each MONITOR/PENDING -> FAULT transition and saturates at 255.
  - Not cleared by fault_clr.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then a legal sequence L_R=001, R_L_D=001, others 100, ticks every 4 clk -> lamps 100 for 3 ticks (RECOVER), then lamps follow inputs with 1-clk latency, fault=0.
- D_R=001 with L_R=001 for 1 clk then legal (CONFIRM=2) -> PENDING for 1 cycle, lamps frozen, return to MONITOR, fault=0. Held for 2 clk -> fault=1, fault_code=10, lamps 100.
- L_D=011 and D_R=001 with L_R=001 for 2 clk -> fault_code=01 (encoding beats conflict); lamps alternate 100/000 on each tick.
- Inputs constant for 15 ticks in MONITOR -> fault=1, fault_code=11 at the 15th tick.
- In FAULT, fault_clr=1 while inputs still conflict -> stays FAULT. Inputs legal plus fault_clr -> RECOVER, fault=0, 3 ticks of all-red, then MONITOR.
- rst pulse mid-flash -> lamps 100, fault=0, fault_code=00, mon_state=11 immediately. With FAULT_COUNT_EN, two faults give fault_count=2.
